// File: rtl/fifo_pkg.sv
// Shared FIFO controller definitions: read/write controller state encoding and bus widths.
package fifo_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned USEDW_W = 9;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } fifo_state_e;

   // Picks one byte of a FIFO word; the low byte is the first byte of the stream.
   function automatic logic [BYTE_W-1:0] sel_byte(input logic [DATA_W-1:0] word,
                                                  input logic              hi);
      return hi ? word[DATA_W-1:BYTE_W] : word[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus byte-stream handshake seen by the read-side controller.
interface fifo_rd_ctrl_if;
   import fifo_pkg::*;

   logic                rd_empty;
   logic [USEDW_W-1:0]  rd_usedw;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_req;
   logic [BYTE_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                busy;
   logic                burst_done;

   modport master (
      input  rd_empty, rd_usedw, rd_data, out_ready,
      output rd_req, out_data, out_valid, busy, burst_done
   );

   modport slave (
      output rd_empty, rd_usedw, rd_data, out_ready,
      input  rd_req, out_data, out_valid, busy, burst_done
   );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// Burst reader for a 16-bit normal-mode FIFO: waits for a full burst, then
// serializes each word into two bytes (low byte first) on a valid/ready stream.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned BURST_LEN = 64
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   fifo_rd_ctrl_if.master  bus
);

   localparam logic [USEDW_W-1:0] BURST_CNT = USEDW_W'(BURST_LEN);

   fifo_state_e         state;
   logic [USEDW_W-1:0]  word_cnt;
   logic                pend;
   logic [1:0]          hold_cnt;
   logic [DATA_W-1:0]   hold;

   logic                rd_req_c;
   logic                accept_c;
   logic                finish_c;

   // A new word may be requested only when the hold register will be free by the time it lands.
   always_comb begin
      rd_req_c = 1'b0;
      accept_c = 1'b0;
      finish_c = 1'b0;
      if (state == READ) begin
         rd_req_c = !pend && (word_cnt < BURST_CNT) && !bus.rd_empty &&
                    ((hold_cnt == 2'd0) || ((hold_cnt == 2'd1) && bus.out_ready));
         finish_c = (word_cnt == BURST_CNT) && !pend && (hold_cnt == 2'd0);
      end
      accept_c = (hold_cnt != 2'd0) && bus.out_ready;
   end

   assign bus.rd_req     = rd_req_c;
   assign bus.out_valid  = (hold_cnt != 2'd0);
   assign bus.out_data   = sel_byte(hold, hold_cnt == 2'd1);
   assign bus.busy       = (state != IDLE);
   assign bus.burst_done = finish_c;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         word_cnt <= '0;
         pend     <= 1'b0;
         hold_cnt <= 2'd0;
         hold     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if ((bus.rd_usedw >= BURST_CNT) && !bus.rd_empty) begin
                  state    <= READ;
                  word_cnt <= '0;
               end
            end
            READ: begin
               if (rd_req_c) begin
                  word_cnt <= word_cnt + USEDW_W'(1);
               end
               if (finish_c) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // pend marks the cycle in which the requested word is on rd_data.
         pend <= rd_req_c;

         // A fresh load takes priority over consuming the last byte of the previous word.
         if (pend) begin
            hold     <= bus.rd_data;
            hold_cnt <= 2'd2;
         end else if (accept_c) begin
            hold_cnt <= hold_cnt - 2'd1;
         end
      end
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 64, giving the number of 16-bit words read per burst; the legal range is 1..256.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: single clock, the FIFO read clock.
REQ-003 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rd_empty, input, 1 bit: FIFO read-side empty flag.
REQ-005 The block SHALL have port rd_usedw, input, 9 bits: FIFO read-side fill level in words.
REQ-006 The block SHALL have port rd_data, input, 16 bits: FIFO output word, valid in the cycle after the cycle in which rd_req is high (normal mode, not show-ahead).
REQ-007 The block SHALL have port rd_req, output, 1 bit: FIFO read request, one word per high cycle.
REQ-008 The block SHALL have port out_data, output, 8 bits: byte stream data.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accept; a byte transfers when out_valid and out_ready are both high.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port burst_done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-013 The state machine SHALL have exactly two states, IDLE and READ.
REQ-014 In IDLE, when rd_usedw >= BURST_LEN and rd_empty = 0, the state SHALL move to READ and clear word_cnt (9 bits) to 0.
REQ-015 In READ, rd_req SHALL be combinational and equal to: pend=0 AND word_cnt < BURST_LEN AND rd_empty=0 AND (hold_cnt=0 OR (hold_cnt=1 AND out_ready=1)).
REQ-016 rd_req SHALL never be high in IDLE or while rd_empty=1, so the FIFO is never underflowed.
REQ-017 In a cycle with rd_req high, the block SHALL set pend to 1 and increment word_cnt.
REQ-018 In a cycle with pend=1, the block SHALL load rd_data into the 16-bit hold register, set hold_cnt=2 and clear pend.
REQ-019 out_valid SHALL equal (hold_cnt != 0).
REQ-020 out_data SHALL be hold[7:0] when hold_cnt=2 and hold[15:8] when hold_cnt=1, so the low byte goes first, matching the 8-to-16 packing order of the write side.
REQ-021 Each accepted byte (out_valid AND out_ready) SHALL decrement hold_cnt.
REQ-022 When a hold load and the acceptance of the last byte coincide, the load SHALL win and hold_cnt SHALL become 2.
REQ-023 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 The latency from rd_req to the first byte on out_valid SHALL be 2 cycles.
REQ-025 The peak rate SHALL be 2 bytes per 3 cycles under continuous out_ready.
REQ-026 READ SHALL return to IDLE when word_cnt = BURST_LEN AND pend=0 AND hold_cnt=0; burst_done SHALL be high for exactly that transition cycle.
REQ-027 If rd_empty rises mid-burst, the block SHALL stall rd_req and stay in READ until data is available again; it SHALL never read a partial burst early.
REQ-028 With BURST_LEN=256, word_cnt SHALL reach 256 with no wrap, because it is 9 bits wide.

Reset
REQ-029 sys_rst_n low SHALL asynchronously force state=IDLE, word_cnt=0, pend=0, hold_cnt=0 and hold=0.
REQ-030 During reset the outputs SHALL be rd_req=0, out_valid=0, out_data=0x00, busy=0 and burst_done=0.
REQ-031 A reset mid-burst SHALL discard any held or in-flight word without flagging it; the FIFO contents already read are lost.

Structure
REQ-032 The state encoding (IDLE/READ) and the widths DATA_W=16, BYTE_W=8 and USEDW_W=9 SHALL live in a shared package, fifo_pkg, reused by the write-side controller.
REQ-033 The block SHALL be a single module with no sub-module; the byte serializer is inline.

Verification
REQ-034 Scenario: rd_usedw=63, BURST_LEN=64 -> state stays IDLE and rd_req is never asserted; then rd_usedw=64 -> busy=1 next cycle.
REQ-035 Scenario: FIFO preloaded with words 0x2211, 0x4433, out_ready=1, BURST_LEN=2 -> bytes 0x11, 0x22, 0x33, 0x44 appear in that order, and the first byte comes 2 cycles after the first rd_req.
REQ-036 Scenario: out_ready held 0 for 10 cycles with the first byte pending -> out_data stays 0x11 with out_valid=1, and no additional rd_req is issued.
REQ-037 Scenario: rd_empty forced to 1 for 5 cycles mid-burst -> rd_req stays 0 for those cycles; the burst then completes with exactly BURST_LEN words and one burst_done pulse.
REQ-038 Scenario: BURST_LEN=256 with a full FIFO -> exactly 512 bytes are transferred, then IDLE, with no word_cnt wrap.
REQ-039 Scenario: sys_rst_n pulsed low after 3 bytes of a burst -> the outputs go to their reset values immediately, and a new burst starts cleanly once rd_usedw >= BURST_LEN.
